// File: rtl/data_mem_access_unit_if.sv
// rtl/data_mem_access_unit_if.sv - data memory strobe/busywait bus between the MEM stage and data memory
interface data_mem_access_unit_if;
  logic        Dmem_Read;
  logic        Dmem_Write;
  logic [31:0] Dmem_Address;
  logic [31:0] Dmem_Write_data;
  logic [2:0]  Dmem_Func3;
  logic [31:0] Dmem_Read_data;
  logic        Dmem_busywait;

  modport master (
    output Dmem_Read, Dmem_Write, Dmem_Address, Dmem_Write_data, Dmem_Func3,
    input  Dmem_Read_data, Dmem_busywait
  );

  modport slave (
    input  Dmem_Read, Dmem_Write, Dmem_Address, Dmem_Write_data, Dmem_Func3,
    output Dmem_Read_data, Dmem_busywait
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - MEM-stage load/store requester with legality check, busywait handshake and timeout
module data_mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Mem_Read,
  input  logic                         Mem_Write,
  input  logic [2:0]                   Func3,
  input  logic [31:0]                  Address,
  input  logic [31:0]                  Store_data,
  data_mem_access_unit_if.master       dmem,
  output logic                         Stall,
  output logic [31:0]                  Load_data,
  output logic                         Load_valid,
  output logic                         Misaligned,
  output logic                         Bus_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 is_read;
  logic                 request;
  logic                 legal;
  logic                 aligned;
  logic                 accept;

  always_comb begin
    request = Mem_Read | Mem_Write;
    legal   = 1'b1;
    if (Mem_Read && Mem_Write)
      legal = 1'b0;
    else if (Mem_Read)
      legal = (Func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (Mem_Write)
      legal = (Func3 inside {3'b000, 3'b001, 3'b010});

    // Func3[1:0] encodes the access size for both signed and unsigned loads
    aligned = 1'b1;
    if (Func3[1:0] == 2'b01 && Address[0])
      aligned = 1'b0;
    if (Func3[1:0] == 2'b10 && Address[1:0] != 2'b00)
      aligned = 1'b0;

    accept     = request & legal & aligned;
    Misaligned = (state == IDLE) & request & ~(legal & aligned);
    Stall      = (state == IDLE) ? accept : (state == ISSUE || state == WAIT);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state                <= IDLE;
      wait_cnt             <= '0;
      is_read              <= 1'b0;
      dmem.Dmem_Read       <= 1'b0;
      dmem.Dmem_Write      <= 1'b0;
      dmem.Dmem_Address    <= '0;
      dmem.Dmem_Write_data <= '0;
      dmem.Dmem_Func3      <= '0;
      Load_data            <= '0;
      Load_valid           <= 1'b0;
      Bus_error            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dmem.Dmem_Address    <= Address;
            dmem.Dmem_Write_data <= Store_data;
            dmem.Dmem_Func3      <= Func3;
            dmem.Dmem_Read       <= Mem_Read;
            dmem.Dmem_Write      <= Mem_Write;
            is_read              <= Mem_Read;
            wait_cnt             <= '0;
            state                <= ISSUE;
          end
        end
        // Grace cycle: memory may not have raised busywait yet
        ISSUE: state <= WAIT;
        WAIT: begin
          if (!dmem.Dmem_busywait) begin
            dmem.Dmem_Read  <= 1'b0;
            dmem.Dmem_Write <= 1'b0;
            if (is_read) begin
              Load_data  <= dmem.Dmem_Read_data;
              Load_valid <= 1'b1;
            end
            state <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            dmem.Dmem_Read  <= 1'b0;
            dmem.Dmem_Write <= 1'b0;
            Bus_error       <= 1'b1;
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          Load_valid <= 1'b0;
          Bus_error  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
